uart_tx_core: RTL and testbench

- Parametrised UART transmit engine: control FSM, shift register, parity generator and line driver in one block.
- Serialises a DATA_WIDTH-bit word as start / data / optional parity / 1 or 2 stop bits.
- Bit timing is set by an external baud-rate tick enable; the engine sits between the TX FIFO/handshake logic and the TX pad.
- Successor to the fixed 8-bit single-stop TX controller. Adds width/bit-order parametrisation, a run-time parity type, a 2-stop-bit mode, baud-tick gating, an accept acknowledge and back-to-back frames.

---
 rtl/uart_tx_core.sv | 145 ++++++++++++++
 tb/tb_uart_tx_core.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmit engine.
// Serialises a DATA_WIDTH-bit word as start, data, optional parity and one or
// two stop bits. The frame advances only on baud ticks; a new word can be
// accepted in the final stop bit so consecutive frames run back to back.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  Data_Ack
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bitCnt;
    logic                  r_parBit;
    logic                  r_parEn;
    logic                  r_stop2;
    logic                  r_txOut;
    logic                  r_busy;
    logic                  r_ack;

    logic                  w_finalStop;
    logic                  w_accept;
    logic                  w_curBit;
    logic [DATA_WIDTH-1:0] w_shiftNext;

    // Decide whether a request is taken this cycle and pick the next data bit.
    always_comb begin
        w_finalStop = (r_state == ST_STOP2) || ((r_state == ST_STOP1) && !r_stop2);
        w_accept    = Data_Valid && tick && ((r_state == ST_IDLE) || w_finalStop);
        if (MSB_FIRST) begin
            w_curBit    = r_shift[DATA_WIDTH-1];
            w_shiftNext = {r_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin
            w_curBit    = r_shift[0];
            w_shiftNext = {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Frame sequencer: state, shift register, bit counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_parBit <= 1'b0;
            r_parEn  <= 1'b0;
            r_stop2  <= 1'b0;
            r_txOut  <= 1'b1;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_accept) begin
                r_state  <= ST_START;
                r_shift  <= P_DATA;
                r_parBit <= (^P_DATA) ^ PAR_TYP;
                r_parEn  <= PAR_EN;
                r_stop2  <= STOP2;
                r_txOut  <= 1'b0;
                r_busy   <= 1'b1;
                r_ack    <= 1'b1;
            end else if (tick) begin
                case (r_state)
                    ST_IDLE: begin
                        r_txOut <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    ST_START: begin
                        r_state  <= ST_DATA;
                        r_bitCnt <= '0;
                        r_txOut  <= w_curBit;
                        r_shift  <= w_shiftNext;
                    end
                    ST_DATA: begin
                        if (r_bitCnt == LAST_IDX) begin
                            if (r_parEn) begin
                                r_state <= ST_PARITY;
                                r_txOut <= r_parBit;
                            end else begin
                                r_state <= ST_STOP1;
                                r_txOut <= 1'b1;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + CNT_W'(1);
                            r_txOut  <= w_curBit;
                            r_shift  <= w_shiftNext;
                        end
                    end
                    ST_PARITY: begin
                        r_state <= ST_STOP1;
                        r_txOut <= 1'b1;
                    end
                    ST_STOP1: begin
                        if (r_stop2) begin
                            r_state <= ST_STOP2;
                            r_txOut <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_txOut <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_STOP2: begin
                        r_state <= ST_IDLE;
                        r_txOut <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_txOut <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign TX_OUT   = r_txOut;
    assign busy     = r_busy;
    assign Data_Ack = r_ack;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: drives three transmitter instances (8-bit LSB first,
// 8-bit MSB first, 5-bit LSB first) from one shared stimulus and compares
// each against a frame-level model every cycle, plus literal frame checks.
module tb_uart_tx_core;

    logic       CLK  = 1'b0;
    logic       tick = 1'b0;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic [8:0] P_DATA;

    logic [2:0] txOut;
    logic [2:0] busyOut;
    logic [2:0] ackOut;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;
    int tickPeriod = 1;
    int tickCnt = 0;

    // Model state per instance: the whole frame as a bit list and a cursor.
    logic [15:0] mFrame[3];
    int          mLen[3];
    int          mPos[3];
    logic        mLine[3];
    logic        mBusy[3];
    logic        mAck[3];

    always #5 CLK = ~CLK;

    uart_tx_core #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .CLK(CLK), .RST(RST), .tick(tick), .P_DATA(P_DATA[7:0]),
        .Data_Valid(Data_Valid), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_OUT(txOut[0]), .busy(busyOut[0]), .Data_Ack(ackOut[0])
    );

    uart_tx_core #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
        .CLK(CLK), .RST(RST), .tick(tick), .P_DATA(P_DATA[7:0]),
        .Data_Valid(Data_Valid), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_OUT(txOut[1]), .busy(busyOut[1]), .Data_Ack(ackOut[1])
    );

    uart_tx_core #(.DATA_WIDTH(5), .MSB_FIRST(1'b0)) dutW5 (
        .CLK(CLK), .RST(RST), .tick(tick), .P_DATA(P_DATA[4:0]),
        .Data_Valid(Data_Valid), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .TX_OUT(txOut[2]), .busy(busyOut[2]), .Data_Ack(ackOut[2])
    );

    function automatic int widthOf(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic bit msbOf(input int k);
        return (k == 1);
    endfunction

    // Build the complete line sequence for one word: start, data, parity, stops.
    function automatic void buildFrame(input logic [8:0] d, input int w, input bit msb,
                                       input bit pe, input bit pt, input bit s2,
                                       output logic [15:0] f, output int len);
        int n;
        bit par;
        bit b;
        f   = '1;
        n   = 0;
        par = pt;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < w; i++) begin
            b = msb ? d[w-1-i] : d[i];
            f[n] = b;
            par ^= b;
            n++;
        end
        if (pe) begin
            f[n] = par;
            n++;
        end
        f[n] = 1'b1;
        n++;
        if (s2) begin
            f[n] = 1'b1;
            n++;
        end
        len = n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud tick generator: period 0 means no ticks at all.
    always @(negedge CLK) begin
        if (tickPeriod == 0) begin
            tick    = 1'b0;
            tickCnt = 0;
        end else begin
            tick    = (tickCnt == 0);
            tickCnt = (tickCnt + 1 >= tickPeriod) ? 0 : tickCnt + 1;
        end
    end

    // Frame-level model: on each tick move to the next bit of the frame, or
    // take a new word when idle or on the last bit of the current frame.
    always @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (RST) begin
                mBusy[k] = 1'b0;
                mLine[k] = 1'b1;
                mAck[k]  = 1'b0;
                mPos[k]  = 0;
                mLen[k]  = 0;
            end else begin
                mAck[k] = 1'b0;
                if (tick) begin
                    if (mBusy[k] && (mPos[k] + 1 < mLen[k])) begin
                        mPos[k]  = mPos[k] + 1;
                        mLine[k] = mFrame[k][mPos[k]];
                    end else if (Data_Valid) begin
                        buildFrame(P_DATA, widthOf(k), msbOf(k), PAR_EN, PAR_TYP, STOP2,
                                   mFrame[k], mLen[k]);
                        mPos[k]  = 0;
                        mLine[k] = mFrame[k][0];
                        mBusy[k] = 1'b1;
                        mAck[k]  = 1'b1;
                    end else begin
                        mBusy[k] = 1'b0;
                        mLine[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge CLK) begin
        if (checkEn) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("tx%0d", k), txOut[k], mLine[k]);
                checkOutput($sformatf("busy%0d", k), busyOut[k], mBusy[k]);
                checkOutput($sformatf("ack%0d", k), ackOut[k], mAck[k]);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Present a word and hold the request until instance 0 acknowledges;
    // returns on the first cycle of the start bit, then scrambles the inputs.
    task automatic applyStimulus(input logic [8:0] d, input logic pe, input logic pt, input logic s2);
        int guard = 0;
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2      = s2;
        Data_Valid = 1'b1;
        do begin
            @(negedge CLK);
            guard++;
        end while (ackOut[0] !== 1'b1 && guard < 100);
        checkOutput("ackSeen", ackOut[0], 1);
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        STOP2      = ~s2;
    endtask

    task automatic captureFrame(input int k, output logic [63:0] seq, output int n, output int acks);
        seq  = '1;
        n    = 0;
        acks = 0;
        while (busyOut[k] === 1'b1 && n < 64) begin
            seq[n] = txOut[k];
            if (ackOut[k] === 1'b1) acks++;
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (busyOut !== 3'b000 && guard < 300) begin
            @(negedge CLK);
            guard++;
        end
        checkOutput("waitIdle", busyOut, 3'b000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] seq;
        logic [15:0] f;
        logic [11:0] vecs[4];
        int          n;
        int          acks;
        int          len;
        int          ackCnt;
        bit          dropped;
        logic        prevTx;
        int          guard;

        RST        = 1'b1;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        tickPeriod = 1;
        waitCycles(3);
        checkEn = 1'b1;
        checkOutput("resetTx", txOut, 3'b111);
        checkOutput("resetBusy", busyOut, 3'b000);
        checkOutput("resetAck", ackOut, 3'b000);
        RST = 1'b0;

        // Pin the model on the even-parity 0xA5 frame.
        buildFrame(9'h0A5, 8, 1'b0, 1'b1, 1'b0, 1'b0, f, len);
        checkOutput("modelLen", len, 11);
        checkOutput("modelA5", f[10:0], 11'h54A);

        // Basic even-parity frame, tick every cycle.
        applyStimulus(9'h0A5, 1'b1, 1'b0, 1'b0);
        captureFrame(0, seq, n, acks);
        checkOutput("t1Busy", n, 11);
        checkOutput("t1Seq", seq[10:0], 11'h54A);
        checkOutput("t1Acks", acks, 1);
        checkOutput("t1IdleTx", txOut[0], 1);
        waitIdle();

        // Slow tick, odd parity, two stop bits.
        tickPeriod = 4;
        applyStimulus(9'h03C, 1'b1, 1'b1, 1'b1);
        captureFrame(0, seq, n, acks);
        checkOutput("t2Busy", n, 48);
        checkOutput("t2Start", seq[3:0], 4'h0);
        checkOutput("t2Data", seq[35:4], 32'h00FFFF00);
        checkOutput("t2Parity", seq[39:36], 4'hF);
        checkOutput("t2Stops", seq[47:40], 8'hFF);
        checkOutput("t2Acks", acks, 1);
        waitIdle();

        // MSB first, no parity.
        tickPeriod = 1;
        applyStimulus(9'h081, 1'b0, 1'b0, 1'b0);
        captureFrame(1, seq, n, acks);
        checkOutput("t3Busy", n, 10);
        checkOutput("t3Seq81", seq[9:0], 10'h302);
        waitIdle();
        applyStimulus(9'h003, 1'b0, 1'b0, 1'b0);
        captureFrame(1, seq, n, acks);
        checkOutput("t3Seq03", seq[9:0], 10'h380);
        waitIdle();

        // Back-to-back frames with the request held.
        @(negedge CLK);
        P_DATA     = 9'h055;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        Data_Valid = 1'b1;
        ackCnt  = 0;
        dropped = 1'b0;
        prevTx  = 1'b0;
        guard   = 0;
        while (ackCnt < 2 && guard < 60) begin
            prevTx = txOut[0];
            @(negedge CLK);
            guard++;
            if (ackOut[0] === 1'b1) begin
                ackCnt++;
                if (ackCnt == 1) P_DATA = 9'h00F;
            end
            if (ackCnt >= 1 && busyOut[0] !== 1'b1) dropped = 1'b1;
        end
        Data_Valid = 1'b0;
        checkOutput("t4Acks", ackCnt, 2);
        checkOutput("t4BusyDrop", dropped, 0);
        checkOutput("t4StopBefore", prevTx, 1);
        checkOutput("t4StartNow", txOut[0], 0);
        captureFrame(0, seq, n, acks);
        checkOutput("t4Busy2", n, 11);
        checkOutput("t4Seq2", seq[10:0], 11'h41E);
        waitIdle();

        // Reset during data bit 3.
        applyStimulus(9'h0C3, 1'b1, 1'b0, 1'b0);
        waitCycles(4);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("t5Tx", txOut, 3'b111);
        checkOutput("t5Busy", busyOut, 3'b000);
        checkOutput("t5Ack", ackOut, 3'b000);
        RST = 1'b0;
        waitCycles(3);
        checkOutput("t5Quiet", txOut, 3'b111);
        applyStimulus(9'h012, 1'b1, 1'b0, 1'b0);
        captureFrame(0, seq, n, acks);
        checkOutput("t5Busy2", n, 11);
        checkOutput("t5Seq", seq[10:0], 11'h424);
        waitIdle();

        // Request without ticks is never accepted.
        tickPeriod = 0;
        waitCycles(2);
        P_DATA     = 9'h01F;
        Data_Valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checkOutput("t6Busy", busyOut, 3'b000);
            checkOutput("t6Tx", txOut, 3'b111);
            checkOutput("t6Ack", ackOut, 3'b000);
        end
        Data_Valid = 1'b0;
        tickPeriod = 1;
        waitCycles(2);

        // Five-bit instance sends exactly five data bits.
        applyStimulus(9'h01F, 1'b0, 1'b0, 1'b0);
        captureFrame(2, seq, n, acks);
        checkOutput("t6W5Busy", n, 7);
        checkOutput("t6W5Seq", seq[6:0], 7'h7E);
        checkOutput("t6W5Acks", acks, 1);
        waitIdle();

        // Assorted words and configurations, checked by the model.
        vecs[0] = {1'b0, 1'b1, 1'b1, 9'h0B4};
        vecs[1] = {1'b1, 1'b0, 1'b0, 9'h06E};
        vecs[2] = {1'b1, 1'b0, 1'b1, 9'h1C9};
        vecs[3] = {1'b1, 1'b1, 1'b1, 9'h013};
        for (int i = 0; i < 4; i++) begin
            tickPeriod = (i % 2) + 1;
            applyStimulus(vecs[i][8:0], vecs[i][9], vecs[i][10], vecs[i][11]);
            waitIdle();
        end

        waitCycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
